// File: rtl/adder_64.sv
// Unsigned WIDTH-bit adder with a full WIDTH+1-bit sum, built on a three-level
// carry-lookahead tree (bit -> group -> block), plus a registered copy of the result.
module adder_64 #(
  parameter int WIDTH = 64,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH:0]   SUM,
  output logic [WIDTH:0]   SUM_Q,
  output logic             COUT_Q
);

  // The tree is three levels deep, so WIDTH must equal GROUP**3 (64 = 4*4*4).
  localparam int NG = WIDTH / GROUP;
  localparam int NB = NG / GROUP;

  // Carry out of each position i of a GROUP-wide slice, in sum-of-products form.
  function automatic logic [GROUP-1:0] lookahead(input logic [GROUP-1:0] gv,
                                                 input logic [GROUP-1:0] pv,
                                                 input logic             cin);
    logic [GROUP-1:0] co;
    logic             acc;
    logic             term;
    co = '0;
    for (int i = 0; i < GROUP; i++) begin
      acc = 1'b0;
      for (int j = 0; j <= i; j++) begin
        term = gv[j];
        for (int k = j + 1; k <= i; k++) term = term & pv[k];
        acc = acc | term;
      end
      term = cin;
      for (int k = 0; k <= i; k++) term = term & pv[k];
      co[i] = acc | term;
    end
    return co;
  endfunction

  // Slice generate: the slice produces a carry-out with zero carry-in.
  function automatic logic group_gen(input logic [GROUP-1:0] gv,
                                     input logic [GROUP-1:0] pv);
    logic acc;
    logic term;
    acc = 1'b0;
    for (int j = 0; j < GROUP; j++) begin
      term = gv[j];
      for (int k = j + 1; k < GROUP; k++) term = term & pv[k];
      acc = acc | term;
    end
    return acc;
  endfunction

  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;
  logic [NG-1:0]    grp_g;
  logic [NG-1:0]    grp_p;
  logic [NB-1:0]    blk_g;
  logic [NB-1:0]    blk_p;
  logic [NB:0]      blk_c;
  logic [NG:0]      grp_c;
  logic [WIDTH:0]   bit_c;

  // Each level's slice writes its own carries; the slice-base carry is then
  // overwritten by the faster value from the level above.
  always_comb begin
    g = A & B;
    p = A ^ B;

    for (int i = 0; i < NG; i++) begin
      grp_g[i] = group_gen(g[i*GROUP +: GROUP], p[i*GROUP +: GROUP]);
      grp_p[i] = &p[i*GROUP +: GROUP];
    end

    for (int b = 0; b < NB; b++) begin
      blk_g[b] = group_gen(grp_g[b*GROUP +: GROUP], grp_p[b*GROUP +: GROUP]);
      blk_p[b] = &grp_p[b*GROUP +: GROUP];
    end

    blk_c          = '0;
    blk_c[NB:1]    = lookahead(blk_g, blk_p, 1'b0);

    grp_c = '0;
    for (int b = 0; b < NB; b++) begin
      grp_c[b*GROUP+1 +: GROUP] = lookahead(grp_g[b*GROUP +: GROUP],
                                            grp_p[b*GROUP +: GROUP], blk_c[b]);
    end
    for (int b = 0; b <= NB; b++) grp_c[b*GROUP] = blk_c[b];

    bit_c = '0;
    for (int i = 0; i < NG; i++) begin
      bit_c[i*GROUP+1 +: GROUP] = lookahead(g[i*GROUP +: GROUP],
                                            p[i*GROUP +: GROUP], grp_c[i]);
    end
    for (int i = 0; i <= NG; i++) bit_c[i*GROUP] = grp_c[i];

    SUM = {bit_c[WIDTH], p ^ bit_c[WIDTH-1:0]};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      SUM_Q  <= '0;
      COUT_Q <= 1'b0;
    end else begin
      SUM_Q  <= SUM;
      COUT_Q <= SUM[WIDTH];
    end
  end

endmodule

// File: tb/tb_adder_64.sv
// Bench for adder_64: directed vector table, exhaustive small operands,
// registered-path reset sequences and randomized operands against an arithmetic model.
module tb_adder_64;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic [64:0] sum;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic [63:0] a;
  logic [63:0] b;
  logic [64:0] sum;
  logic [64:0] sum_q;
  logic        cout_q;

  int n_checks = 0;
  int n_fails  = 0;

  logic [64:0] exp_q[$];
  vec_t        vecs[$];

  adder_64 dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .A      (a),
    .B      (b),
    .SUM    (sum),
    .SUM_Q  (sum_q),
    .COUT_Q (cout_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [64:0] ref_sum(input logic [63:0] x, input logic [63:0] y);
    return {1'b0, x} + {1'b0, y};
  endfunction

  task automatic check65(input string name, input logic [64:0] act, input logic [64:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic apply_comb(input logic [63:0] x, input logic [63:0] y);
    a = x;
    b = y;
    #1;
  endtask

  initial begin
    logic [64:0] one65;
    logic [63:0] one64;
    logic [64:0] held;
    logic [63:0] ra;
    logic [63:0] rb;
    logic [64:0] exp;

    rst_n = 1'b0;
    a     = '0;
    b     = '0;
    one65 = 65'd1;
    one64 = 64'd1;

    // Directed table
    vecs.push_back('{64'h0, 64'h0, 65'h0});
    vecs.push_back('{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 65'h1_0000_0000_0000_0000});
    vecs.push_back('{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 65'h1_FFFF_FFFF_FFFF_FFFE});
    vecs.push_back('{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 65'h1_0000_0000_0000_0000});
    vecs.push_back('{64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 65'h0_FFFF_FFFF_FFFF_FFFF});
    vecs.push_back('{64'h0000_0000_FFFF_FFF0, 64'h0000_0000_0000_0010, 65'h0_0000_0001_0000_0000});
    vecs.push_back('{64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 65'h0_2222_2222_2222_2211});
    for (int k = 1; k <= 16; k++)
      vecs.push_back('{(one64 << (4*k)) - 64'd1, 64'h1, one65 << (4*k)});

    foreach (vecs[i]) begin
      apply_comb(vecs[i].a, vecs[i].b);
      check65($sformatf("table[%0d] SUM", i), sum, vecs[i].sum);
    end

    // Exhaustive small operands
    for (int x = 0; x <= 32; x++) begin
      for (int y = 0; y <= 32; y++) begin
        apply_comb(64'(x), 64'(y));
        check65("small SUM", sum, 65'(x + y));
      end
    end

    // Reset held for two edges clears the registered outputs
    @(negedge clk);
    a = 64'd5;
    b = 64'd7;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check65("reset SUM_Q", sum_q, 65'h0);
    check1("reset COUT_Q", cout_q, 1'b0);

    // First edge after release loads the current sum
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check65("release SUM_Q", sum_q, 65'd12);
    check1("release COUT_Q", cout_q, 1'b0);

    // Load a carry-out result, then assert reset between edges
    @(negedge clk);
    a = 64'hFFFF_FFFF_FFFF_FFFF;
    b = 64'hFFFF_FFFF_FFFF_FFFF;
    @(posedge clk);
    #1;
    held = 65'h1_FFFF_FFFF_FFFF_FFFE;
    check65("maxmax SUM_Q", sum_q, held);
    check1("maxmax COUT_Q", cout_q, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check65("midcycle reset SUM_Q holds", sum_q, held);
    check1("midcycle reset COUT_Q holds", cout_q, 1'b1);
    check65("SUM during reset", sum, held);
    @(posedge clk);
    #1;
    check65("sync reset SUM_Q", sum_q, 65'h0);
    check1("sync reset COUT_Q", cout_q, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    a = 64'hFFFF_FFFF_FFFF_FFFF;
    b = 64'h1;
    @(posedge clk);
    #1;
    check65("post reset SUM_Q", sum_q, 65'h1_0000_0000_0000_0000);
    check1("post reset COUT_Q", cout_q, 1'b1);

    // Randomized operands, some biased towards long carry chains
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      ra = {$urandom(), $urandom()};
      case ($urandom_range(0, 3))
        0:       rb = ~ra;
        1:       rb = ~ra + 64'd1;
        default: rb = {$urandom(), $urandom()};
      endcase
      a = ra;
      b = rb;
      #1;
      exp = ref_sum(ra, rb);
      check65("random SUM", sum, exp);
      exp_q.push_back(exp);
      @(posedge clk);
      #1;
      exp = exp_q.pop_front();
      check65("random SUM_Q", sum_q, exp);
      check1("random COUT_Q", cout_q, exp[64]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
